// File: rtl/qspi_wr_sequencer_pkg.sv
// qspi_wr_sequencer_pkg: flash opcodes, address-size and request encodings, FSM states
package qspi_wr_sequencer_pkg;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_SE   = 8'h20;
  localparam logic [7:0] OP_CE   = 8'hC7;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [1:0] ASEL_NONE = 2'b00;
  localparam logic [1:0] ASEL_3B   = 2'b01;
  localparam logic [1:0] REQ_PP  = 2'b00;
  localparam logic [1:0] REQ_SE  = 2'b01;
  localparam logic [1:0] REQ_CE  = 2'b10;
  localparam logic [1:0] REQ_BAD = 2'b11;
  typedef enum logic [3:0] {
    S_IDLE, S_WREN_GO, S_WREN_WT, S_OP_GO, S_OP_WT, S_GAP, S_POLL_GO, S_POLL_WT, S_DONE
  } state_t;
endpackage

// File: rtl/qspi_wr_sequencer.sv
// qspi_wr_sequencer: WREN, program/erase, then RDSR polling until WIP clears or the poll budget runs out
module qspi_wr_sequencer
  import qspi_wr_sequencer_pkg::*;
#(
  parameter int POLL_MAX = 65535,
  parameter int POLL_GAP = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_len,
  output logic        rsp_valid,
  output logic        rsp_timeout,
  output logic        rsp_bad_op,
  output logic [15:0] rsp_polls,
  output logic        busy,
  output logic        fsm_start,
  input  logic        fsm_done,
  output logic [7:0]  fsm_cmd_opcode,
  output logic [31:0] fsm_addr,
  output logic [1:0]  fsm_addr_bytes_sel,
  output logic [31:0] fsm_len_bytes,
  output logic        fsm_dir,
  input  logic        fsm_rx_wen,
  input  logic [31:0] fsm_rx_data,
  output logic        rx_fifo_wen
);
  state_t      state;
  logic [1:0]  op_q;
  logic [31:0] addr_q, len_q;
  logic [15:0] gap_cnt;
  logic        first, wip, wip_now, unused;
  // a status byte arriving in the same cycle as done must decide the exit
  assign wip_now     = fsm_rx_wen ? fsm_rx_data[0] : wip;
  assign unused      = ^fsm_rx_data[31:1];
  assign req_ready   = state == S_IDLE;
  assign busy        = state != S_IDLE;
  assign rx_fifo_wen = fsm_rx_wen & (state != S_POLL_WT);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state              <= S_IDLE;
      op_q               <= '0;
      addr_q             <= '0;
      len_q              <= '0;
      gap_cnt            <= '0;
      first              <= 1'b0;
      wip                <= 1'b1;
      rsp_valid          <= 1'b0;
      rsp_timeout        <= 1'b0;
      rsp_bad_op         <= 1'b0;
      rsp_polls          <= '0;
      fsm_start          <= 1'b0;
      fsm_cmd_opcode     <= '0;
      fsm_addr           <= '0;
      fsm_addr_bytes_sel <= '0;
      fsm_len_bytes      <= '0;
      fsm_dir            <= 1'b0;
    end else begin
      fsm_start <= 1'b0;
      rsp_valid <= 1'b0;
      first     <= 1'b0;
      case (state)
        S_IDLE: if (req_valid) begin
          op_q        <= req_op;
          addr_q      <= req_addr;
          len_q       <= req_len;
          rsp_polls   <= '0;
          rsp_timeout <= 1'b0;
          rsp_bad_op  <= req_op == REQ_BAD;
          if (req_op == REQ_BAD) begin
            state     <= S_DONE;
            rsp_valid <= 1'b1;
          end else begin
            state              <= S_WREN_GO;
            fsm_start          <= 1'b1;
            fsm_cmd_opcode     <= OP_WREN;
            fsm_addr           <= '0;
            fsm_addr_bytes_sel <= ASEL_NONE;
            fsm_len_bytes      <= '0;
            fsm_dir            <= 1'b0;
          end
        end
        S_WREN_GO: begin
          state <= S_WREN_WT;
          first <= 1'b1;
        end
        S_WREN_WT: if (fsm_done && !first) begin
          state              <= S_OP_GO;
          fsm_start          <= 1'b1;
          fsm_cmd_opcode     <= op_q == REQ_PP ? OP_PP : op_q == REQ_SE ? OP_SE : OP_CE;
          fsm_addr           <= op_q == REQ_CE ? '0 : addr_q;
          fsm_addr_bytes_sel <= op_q == REQ_CE ? ASEL_NONE : ASEL_3B;
          fsm_len_bytes      <= op_q == REQ_PP ? len_q : '0;
          fsm_dir            <= 1'b0;
        end
        S_OP_GO: begin
          state <= S_OP_WT;
          first <= 1'b1;
        end
        S_OP_WT: if (fsm_done && !first) begin
          state   <= S_GAP;
          gap_cnt <= '0;
        end
        S_GAP: if (gap_cnt == 16'(POLL_GAP - 1)) begin
          state              <= S_POLL_GO;
          fsm_start          <= 1'b1;
          fsm_cmd_opcode     <= OP_RDSR;
          fsm_addr           <= '0;
          fsm_addr_bytes_sel <= ASEL_NONE;
          fsm_len_bytes      <= 32'd1;
          fsm_dir            <= 1'b1;
          wip                <= 1'b1;
          rsp_polls          <= rsp_polls + {15'd0, rsp_polls != 16'hFFFF};
        end else
          gap_cnt <= gap_cnt + 16'd1;
        S_POLL_GO: begin
          state <= S_POLL_WT;
          first <= 1'b1;
        end
        S_POLL_WT: begin
          if (fsm_rx_wen)
            wip <= fsm_rx_data[0];
          if (fsm_done && !first) begin
            if (!wip_now || rsp_polls >= 16'(POLL_MAX)) begin
              state       <= S_DONE;
              rsp_valid   <= 1'b1;
              rsp_timeout <= wip_now;
            end else begin
              state   <= S_GAP;
              gap_cnt <= '0;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_qspi_wr_sequencer.sv
// tb_qspi_wr_sequencer: qspi_fsm/flash status responder plus a rule-level model checked every cycle
module tb_qspi_wr_sequencer;
  localparam int PMAX = 4;
  localparam int PGAP = 3;
  localparam int LAT  = 4;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_addr = '0;
  logic [31:0] req_len = '0;
  logic        rsp_valid, rsp_timeout, rsp_bad_op;
  logic [15:0] rsp_polls;
  logic        busy, fsm_start, fsm_done, fsm_dir, fsm_rx_wen, rx_fifo_wen;
  logic [7:0]  fsm_cmd_opcode;
  logic [31:0] fsm_addr, fsm_len_bytes, fsm_rx_data;
  logic [1:0]  fsm_addr_bytes_sel;
  always #5 clk = ~clk;
  qspi_wr_sequencer #(.POLL_MAX(PMAX), .POLL_GAP(PGAP)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_timeout(rsp_timeout), .rsp_bad_op(rsp_bad_op),
    .rsp_polls(rsp_polls), .busy(busy), .fsm_start(fsm_start), .fsm_done(fsm_done),
    .fsm_cmd_opcode(fsm_cmd_opcode), .fsm_addr(fsm_addr),
    .fsm_addr_bytes_sel(fsm_addr_bytes_sel), .fsm_len_bytes(fsm_len_bytes),
    .fsm_dir(fsm_dir), .fsm_rx_wen(fsm_rx_wen), .fsm_rx_data(fsm_rx_data),
    .rx_fifo_wen(rx_fifo_wen)
  );
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  // driver-owned flash behaviour knobs
  int clear_at = 0;
  bit skip_even = 1'b0;
  bit echo_rx = 1'b0;
  // monitor-owned observations
  logic [63:0] op_log = '0;
  int n_starts = 0;
  int rsp_count = 0;
  int fifo_cnt = 0;
  // model state
  bit m_busy = 1'b0, m_act = 1'b0, m_wip = 1'b1, e_to = 1'b0, e_bad = 1'b0;
  int nxt_cyc = -1, rsp_cyc = -1, st_cyc = 0, kind = 0, nxt_kind = 0, m_polls = 0;
  logic [1:0]  r_op = '0;
  logic [31:0] r_addr = '0, r_len = '0;
  logic [15:0] e_polls = '0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [74:0] cfg_exp(input int k, input logic [1:0] op, input logic [31:0] a, input logic [31:0] l);
    if (k == 0) return {8'h06, 32'h0, 2'b00, 32'h0, 1'b0};
    if (k == 2) return {8'h05, 32'h0, 2'b00, 32'd1, 1'b1};
    if (op == 2'b00) return {8'h02, a, 2'b01, l, 1'b0};
    if (op == 2'b01) return {8'h20, a, 2'b01, 32'h0, 1'b0};
    return {8'hC7, 32'h0, 2'b00, 32'h0, 1'b0};
  endfunction
  function automatic logic [74:0] cfg_act();
    return {fsm_cmd_opcode, fsm_addr_bytes_sel == 2'b00 ? 32'h0 : fsm_addr, fsm_addr_bytes_sel, fsm_len_bytes, fsm_dir};
  endfunction
  // qspi_fsm + flash stand-in; also echoes a stale done in the first wait cycle, which must be ignored
  initial begin
    int t;
    bit active;
    logic [7:0] cur;
    int poll_n;
    t = 0; active = 1'b0; cur = '0; poll_n = 0;
    fsm_done = 1'b0; fsm_rx_wen = 1'b0; fsm_rx_data = '0;
    forever begin
      @(posedge clk); #1;
      fsm_done = 1'b0;
      fsm_rx_wen = 1'b0;
      if (!resetn) begin
        active = 1'b0;
        continue;
      end
      if (fsm_start) begin
        active = 1'b1; t = 0; cur = fsm_cmd_opcode;
        if (cur == 8'h06) poll_n = 0;
        if (cur == 8'h05) poll_n++;
      end else if (active) begin
        t++;
        if (t == 1 || t == LAT) fsm_done = 1'b1;
        if (t == LAT) active = 1'b0;
        if (t == LAT - 1 && cur == 8'h05 && !(skip_even && poll_n % 2 == 0)) begin
          fsm_rx_wen = 1'b1;
          fsm_rx_data = (clear_at != 0 && poll_n >= clear_at) ? 32'hFFFF_FFFE : 32'h0000_0001;
        end
        if (t == LAT - 1 && cur == 8'h02 && echo_rx) begin
          fsm_rx_wen = 1'b1;
          fsm_rx_data = 32'h0000_00AB;
        end
      end
    end
  end
  // compare process: expected outputs derived from sequencing rules, checked every cycle
  initial begin
    forever begin
      @(posedge clk); #2;
      cyc++;
      if (!resetn) begin
        m_busy = 1'b0; m_act = 1'b0; nxt_cyc = -1; rsp_cyc = -1;
        e_to = 1'b0; e_bad = 1'b0; e_polls = '0;
        continue;
      end
      chk("busy", 128'(busy), 128'(m_busy));
      chk("req_ready", 128'(req_ready), 128'(!m_busy));
      chk("fsm_start", 128'(fsm_start), 128'(cyc == nxt_cyc));
      if (fsm_start) chk("cmd_cfg", 128'(cfg_act()), 128'(cfg_exp(nxt_kind, r_op, r_addr, r_len)));
      if (m_act) chk("cfg_hold", 128'(cfg_act()), 128'(cfg_exp(kind, r_op, r_addr, r_len)));
      chk("rsp_valid", 128'(rsp_valid), 128'(cyc == rsp_cyc));
      if (rsp_valid || !m_busy)
        chk("rsp_fields", 128'({rsp_timeout, rsp_bad_op, rsp_polls}), 128'({e_to, e_bad, e_polls}));
      chk("rx_fifo_wen", 128'(rx_fifo_wen), 128'(fsm_rx_wen && !(m_act && kind == 2)));
      if (rx_fifo_wen) fifo_cnt++;
      if (rsp_valid) rsp_count++;
      if (!m_busy && req_valid) begin
        m_busy = 1'b1; r_op = req_op; r_addr = req_addr; r_len = req_len;
        op_log = '0; n_starts = 0; fifo_cnt = 0; m_polls = 0;
        e_polls = '0; e_to = 1'b0; e_bad = req_op == 2'b11;
        if (req_op == 2'b11) rsp_cyc = cyc + 1;
        else begin
          nxt_cyc = cyc + 1;
          nxt_kind = 0;
        end
      end else if (cyc == rsp_cyc)
        m_busy = 1'b0;
      if (fsm_start) begin
        m_act = 1'b1; kind = nxt_kind; st_cyc = cyc; nxt_cyc = -1;
        op_log = {op_log[55:0], fsm_cmd_opcode};
        n_starts++;
        if (kind == 2) begin
          m_polls++;
          m_wip = 1'b1;
        end
      end else if (m_act) begin
        if (kind == 2 && fsm_rx_wen) m_wip = fsm_rx_data[0];
        if (fsm_done && cyc >= st_cyc + 2) begin
          m_act = 1'b0;
          if (kind == 0) begin
            nxt_kind = 1; nxt_cyc = cyc + 1;
          end else if (kind == 1 || (m_wip && m_polls < PMAX)) begin
            nxt_kind = 2; nxt_cyc = cyc + PGAP + 1;
          end else begin
            rsp_cyc = cyc + 1; e_to = m_wip; e_polls = 16'(m_polls);
          end
        end
      end
    end
  end
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] l);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!req_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    req_op = op; req_addr = a; req_len = l; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask
  task automatic wait_rsp(input int target);
    int n;
    n = 0;
    while (rsp_count < target && n < 1000) begin
      @(posedge clk); #3;
      n++;
    end
    chk("rsp_arrived", 128'(rsp_count >= target), 128'(1));
  endtask
  task automatic wait_starts(input int target);
    int n;
    n = 0;
    while (n_starts < target && n < 200) begin
      @(posedge clk); #3;
      n++;
    end
    chk("start_seen", 128'(n_starts >= target), 128'(1));
  endtask
  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] l,
                     input logic [63:0] exp_log, input int exp_polls, input bit exp_to,
                     input bit exp_bad, input int exp_fifo);
    int c0;
    c0 = rsp_count;
    issue(op, a, l);
    wait_rsp(c0 + 1);
    chk("opcode_log", 128'(op_log), 128'(exp_log));
    chk("lit_polls", 128'(rsp_polls), 128'(exp_polls));
    chk("lit_timeout", 128'(rsp_timeout), 128'(exp_to));
    chk("lit_bad_op", 128'(rsp_bad_op), 128'(exp_bad));
    chk("lit_fifo_wen", 128'(fifo_cnt), 128'(exp_fifo));
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, 128'(req_ready), 128'(1));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_start"}, 128'(fsm_start), 128'(0));
    chk({tag, "_rsp"}, 128'({rsp_valid, rsp_timeout, rsp_bad_op, rsp_polls}), 128'(0));
    chk({tag, "_cfg"}, 128'({fsm_cmd_opcode, fsm_addr, fsm_addr_bytes_sel, fsm_len_bytes, fsm_dir}), 128'(0));
  endtask
  initial begin
    int c0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    resetn = 1'b1;
    clear_at = 3; skip_even = 1'b0; echo_rx = 1'b1;
    run(2'b00, 32'h0000_1000, 32'd4, 64'h06_02_05_05_05, 3, 1'b0, 1'b0, 1);
    clear_at = 1; echo_rx = 1'b0;
    run(2'b01, 32'h0002_0000, 32'd0, 64'h06_20_05, 1, 1'b0, 1'b0, 0);
    clear_at = 0; skip_even = 1'b1;
    run(2'b10, 32'h0000_0000, 32'd0, 64'h06_C7_05_05_05_05, 4, 1'b1, 1'b0, 0);
    skip_even = 1'b0;
    run(2'b11, 32'h0000_0123, 32'd9, 64'h0, 0, 1'b0, 1'b1, 0);
    clear_at = 2;
    c0 = rsp_count;
    issue(2'b00, 32'h0000_2000, 32'd16);
    wait_starts(2);
    @(posedge clk); #1;
    req_op = 2'b01; req_addr = 32'h0000_0055; req_valid = 1'b1;
    chk("drop_ready0", 128'(req_ready), 128'(0));
    @(posedge clk); #1;
    chk("drop_ready1", 128'(req_ready), 128'(0));
    req_valid = 1'b0;
    wait_rsp(c0 + 1);
    chk("drop_log", 128'(op_log), 128'(64'h06_02_05_05));
    chk("drop_polls", 128'(rsp_polls), 128'(2));
    clear_at = 1;
    run(2'b01, 32'h0003_0000, 32'd0, 64'h06_20_05, 1, 1'b0, 1'b0, 0);
    clear_at = 0;
    issue(2'b01, 32'h0004_0000, 32'd0);
    wait_starts(3);
    @(posedge clk); #4;
    resetn = 1'b0;
    #1;
    chk_idle_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (4) @(posedge clk);
    clear_at = 2;
    run(2'b01, 32'h0005_0000, 32'd0, 64'h06_20_05_05, 2, 1'b0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end
endmodule
